// File: rtl/cntr_sched.sv
// ---------------------------------------------------------------------------
// cntr_sched
//   One delay counter shared round-robin by N_REQ requesters. An idle block
//   picks the next requesting index at or after the pointer. It grants that
//   index, loads its delay and counts down to zero. It then pulses done for
//   one cycle and returns to idle with the pointer moved past the owner.
//   abort cancels a running countdown and produces an aborted pulse instead
//   of done.
//
// Ports
//   CLK      rising-edge clock
//   RST      asynchronous active-high reset
//   req      per-requester request level, sampled only in IDLE
//   dly      packed delays, requester i at [i*DLY_WIDTH +: DLY_WIDTH]
//   abort    cancels a run in progress (ignored outside RUN)
//   gnt      one-hot grant to the current owner, zero when no owner
//   done     one-cycle completion pulse, same bit as gnt
//   aborted  one-cycle pulse after a cancelled run
//   busy     high while a run or its done cycle is in progress
//   cnt      remaining delay cycles
// ---------------------------------------------------------------------------
module cntr_sched #(
    parameter int N_REQ     = 4,
    parameter int DLY_WIDTH = 8,
    parameter int PTR_WIDTH = $clog2(N_REQ)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DLY_WIDTH-1:0] dly,
    input  logic                       abort,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic                       aborted,
    output logic                       busy,
    output logic [DLY_WIDTH-1:0]       cnt
);

    // One extra bit so ptr + offset never overflows before the modulo fold.
    localparam int SUM_W = PTR_WIDTH + 1;
    localparam logic [N_REQ-1:0] ONE_L = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [PTR_WIDTH-1:0]   ptr_r;
    logic [PTR_WIDTH-1:0]   owner_r;
    logic [DLY_WIDTH-1:0]   cnt_r;
    logic [N_REQ-1:0]       gnt_r;
    logic [N_REQ-1:0]       done_r;
    logic                   aborted_r;
    logic                   busy_r;

    logic [SUM_W-1:0]       sum_s;
    logic [PTR_WIDTH-1:0]   win_s;
    logic                   found_s;
    logic [DLY_WIDTH-1:0]   dly_sel_s;
    logic [PTR_WIDTH-1:0]   nxt_ptr_s;

    // Round-robin search: first set req bit from ptr upward, wrapping at N_REQ.
    always_comb begin
        found_s = 1'b0;
        win_s   = {PTR_WIDTH{1'b0}};
        sum_s   = {SUM_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            sum_s = {1'b0, ptr_r} + SUM_W'(k);
            if (sum_s >= SUM_W'(N_REQ)) begin
                sum_s = sum_s - SUM_W'(N_REQ);
            end else begin
                sum_s = sum_s;
            end
            if (!found_s && req[sum_s[PTR_WIDTH-1:0]]) begin
                found_s = 1'b1;
                win_s   = sum_s[PTR_WIDTH-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Delay field of the selected winner (constant-index mux, no variable part-select).
    always_comb begin
        dly_sel_s = {DLY_WIDTH{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (win_s == PTR_WIDTH'(i)) begin
                dly_sel_s = dly[i*DLY_WIDTH +: DLY_WIDTH];
            end else begin
                dly_sel_s = dly_sel_s;
            end
        end
    end

    // Pointer after the current owner, folded explicitly for non-power-of-two N_REQ.
    always_comb begin
        if (owner_r == PTR_WIDTH'(N_REQ - 1)) begin
            nxt_ptr_s = {PTR_WIDTH{1'b0}};
        end else begin
            nxt_ptr_s = owner_r + PTR_WIDTH'(1);
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            ptr_r     <= {PTR_WIDTH{1'b0}};
            owner_r   <= {PTR_WIDTH{1'b0}};
            cnt_r     <= {DLY_WIDTH{1'b0}};
            gnt_r     <= {N_REQ{1'b0}};
            done_r    <= {N_REQ{1'b0}};
            aborted_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            aborted_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        gnt_r   <= ONE_L << win_s;
                        cnt_r   <= dly_sel_s;
                        owner_r <= win_s;
                        busy_r  <= 1'b1;
                        // A zero delay skips RUN; done must show in the DONE cycle.
                        if (dly_sel_s == {DLY_WIDTH{1'b0}}) begin
                            state_r <= ST_DONE;
                            done_r  <= ONE_L << win_s;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // abort outranks the final countdown step.
                    if (abort) begin
                        state_r   <= ST_IDLE;
                        gnt_r     <= {N_REQ{1'b0}};
                        cnt_r     <= {DLY_WIDTH{1'b0}};
                        busy_r    <= 1'b0;
                        ptr_r     <= nxt_ptr_s;
                        aborted_r <= 1'b1;
                    end else if (cnt_r == DLY_WIDTH'(1)) begin
                        state_r <= ST_DONE;
                        cnt_r   <= {DLY_WIDTH{1'b0}};
                        done_r  <= gnt_r;
                    end else begin
                        cnt_r <= cnt_r - DLY_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= {N_REQ{1'b0}};
                    done_r  <= {N_REQ{1'b0}};
                    busy_r  <= 1'b0;
                    ptr_r   <= nxt_ptr_s;
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= {N_REQ{1'b0}};
                    done_r  <= {N_REQ{1'b0}};
                    cnt_r   <= {DLY_WIDTH{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_r;
    assign done    = done_r;
    assign aborted = aborted_r;
    assign busy    = busy_r;
    assign cnt     = cnt_r;

endmodule

// File: tb/tb_cntr_sched.sv
// ---------------------------------------------------------------------------
// tb_cntr_sched
//   Directed bench for cntr_sched (N_REQ=4, DLY_WIDTH=8) with hand-computed
//   expected values. Inputs change 1 ns after a rising edge; outputs are
//   checked at that same point.
// ---------------------------------------------------------------------------
module tb_cntr_sched;

    logic        CLK;
    logic        RST;
    logic [3:0]  req;
    logic [31:0] dly;
    logic        abort;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        aborted;
    logic        busy;
    logic [7:0]  cnt;

    int n_cmp;
    int n_err;

    cntr_sched #(
        .N_REQ     (4),
        .DLY_WIDTH (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .req     (req),
        .dly     (dly),
        .abort   (abort),
        .gnt     (gnt),
        .done    (done),
        .aborted (aborted),
        .busy    (busy),
        .cnt     (cnt)
    );

    // Free-running clock, 10 ns period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Single comparison point for every check.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_dly(input int idx, input logic [7:0] val);
        dly[idx*8 +: 8] = val;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] e_gnt, input logic [3:0] e_done,
                              input logic [7:0] e_cnt, input logic e_busy, input logic e_ab);
        check_val({tag, ".gnt"},     32'(gnt),     32'(e_gnt));
        check_val({tag, ".done"},    32'(done),    32'(e_done));
        check_val({tag, ".cnt"},     32'(cnt),     32'(e_cnt));
        check_val({tag, ".busy"},    32'(busy),    32'(e_busy));
        check_val({tag, ".aborted"}, 32'(aborted), 32'(e_ab));
    endtask

    initial begin
        logic [3:0] rr_order [5];
        n_cmp = 0;
        n_err = 0;
        RST   = 1'b1;
        req   = 4'b0000;
        dly   = 32'h0;
        abort = 1'b0;

        // Reset state, checked before any clock edge.
        #2;
        check_outs("reset", 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0);
        tick();
        RST = 1'b0;
        tick();
        check_outs("idle", 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0);

        // Round-robin: all requesting, delay 1 -> order 0,1,2,3,0.
        rr_order[0] = 4'b0001;
        rr_order[1] = 4'b0010;
        rr_order[2] = 4'b0100;
        rr_order[3] = 4'b1000;
        rr_order[4] = 4'b0001;
        req = 4'b1111;
        dly = {8'd1, 8'd1, 8'd1, 8'd1};
        for (int g = 0; g < 5; g++) begin
            tick();
            check_outs($sformatf("rr%0d_run", g), rr_order[g], 4'b0000, 8'd1, 1'b1, 1'b0);
            tick();
            check_outs($sformatf("rr%0d_done", g), rr_order[g], rr_order[g], 8'd0, 1'b1, 1'b0);
            tick();
            check_outs($sformatf("rr%0d_idle", g), 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0);
        end
        req = 4'b0000;
        tick();
        check_outs("rr_quiet", 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0);

        // Single request, delay 3; req drops during RUN and the grant holds.
        req = 4'b0100;
        set_dly(2, 8'd3);
        tick();
        check_outs("single_c3", 4'b0100, 4'b0000, 8'd3, 1'b1, 1'b0);
        req = 4'b0000;
        set_dly(2, 8'd9);
        tick();
        check_outs("single_c2", 4'b0100, 4'b0000, 8'd2, 1'b1, 1'b0);
        tick();
        check_outs("single_c1", 4'b0100, 4'b0000, 8'd1, 1'b1, 1'b0);
        tick();
        check_outs("single_done", 4'b0100, 4'b0100, 8'd0, 1'b1, 1'b0);
        tick();
        check_outs("single_idle", 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0);

        // Zero delay with ptr=3: search wraps to index 0, enters DONE directly.
        req = 4'b0001;
        set_dly(0, 8'd0);
        tick();
        check_outs("zero_done", 4'b0001, 4'b0001, 8'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        check_outs("zero_idle", 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0);

        // Abort owner 1 at cnt=5; next grant goes to 2.
        req = 4'b0010;
        set_dly(1, 8'd7);
        tick();
        check_outs("ab_c7", 4'b0010, 4'b0000, 8'd7, 1'b1, 1'b0);
        tick();
        tick();
        check_outs("ab_c5", 4'b0010, 4'b0000, 8'd5, 1'b1, 1'b0);
        abort = 1'b1;
        req   = 4'b1111;
        dly   = {8'd1, 8'd1, 8'd1, 8'd1};
        tick();
        abort = 1'b0;
        check_outs("ab_hit", 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b1);
        tick();
        check_outs("ab_next", 4'b0100, 4'b0000, 8'd1, 1'b1, 1'b0);
        tick();
        check_outs("ab_next_done", 4'b0100, 4'b0100, 8'd0, 1'b1, 1'b0);
        // abort in DONE is ignored.
        abort = 1'b1;
        req   = 4'b0000;
        tick();
        abort = 1'b0;
        check_outs("ab_in_done", 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0);

        // Abort on the last RUN cycle beats the transition to DONE.
        req = 4'b1000;
        set_dly(3, 8'd1);
        tick();
        check_outs("ablast_run", 4'b1000, 4'b0000, 8'd1, 1'b1, 1'b0);
        abort = 1'b1;
        req   = 4'b0000;
        tick();
        abort = 1'b0;
        check_outs("ablast_hit", 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b1);
        tick();
        check_outs("ablast_after", 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0);

        // Async reset mid-RUN at cnt=4, then req=1010 grants index 1.
        req = 4'b0001;
        set_dly(0, 8'd6);
        tick();
        req = 4'b0000;
        tick();
        tick();
        check_outs("ar_c4", 4'b0001, 4'b0000, 8'd4, 1'b1, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        check_outs("ar_rst", 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0);
        #1;
        RST = 1'b0;
        req = 4'b1010;
        set_dly(1, 8'd2);
        tick();
        check_outs("ar_grant", 4'b0010, 4'b0000, 8'd2, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cntr_sched.md
CNTR_SCHED -- requirements
Module: cntr_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the delay counter (2..16).
REQ-002 Parameter DLY_WIDTH, default 8, width of delay values and of the counter.
REQ-003 Parameter PTR_WIDTH, default $clog2(N_REQ), width of the round-robin pointer.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RST  input  1  reset, asynchronous and active-high.
REQ-006 req  input  N_REQ  per-requester request level.
REQ-007 dly  input  N_REQ*DLY_WIDTH  packed delays; requester i uses bits [i*DLY_WIDTH +: DLY_WIDTH].
REQ-008 abort  input  1  cancels the running delay.
REQ-009 gnt  output  N_REQ  one-hot grant to the current owner; all-zero when no owner.
REQ-010 done  output  N_REQ  one-cycle completion pulse to the owner.
REQ-011 aborted  output  1  one-cycle pulse when a run is cancelled.
REQ-012 busy  output  1  high in RUN and DONE.
REQ-013 cnt  output  DLY_WIDTH  remaining delay cycles.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE, all registered.
REQ-015 In IDLE with req != 0, the block SHALL select the first set req bit, searching from index ptr upward modulo N_REQ.
REQ-016 On that edge the block SHALL set gnt to one-hot(winner), load cnt with dly[winner], and record the winner as owner.
REQ-017 On that edge the next state SHALL be DONE if the loaded delay is 0, otherwise RUN.
REQ-018 In RUN, cnt SHALL decrement by 1 each edge.
REQ-019 In RUN with cnt == 1, the edge SHALL set cnt to 0 and enter DONE.
REQ-020 A delay D > 0 SHALL therefore spend exactly D cycles in RUN, with cnt showing D, D-1, ..., 1.
REQ-021 In DONE, done[owner] SHALL be 1 and gnt SHALL remain asserted.
REQ-022 The edge leaving DONE SHALL enter IDLE, clear gnt, and set ptr to (owner + 1) mod N_REQ.
REQ-023 The block SHALL hold at least one IDLE cycle between consecutive grants.
REQ-024 In RUN, abort = 1 SHALL take priority over the cnt == 1 transition.
REQ-025 On an abort edge the block SHALL enter IDLE, clear gnt, set cnt to 0, set ptr to (owner + 1) mod N_REQ, and pulse aborted for one cycle.
REQ-026 An aborted run SHALL NOT pulse done.
REQ-027 abort SHALL be ignored in IDLE and DONE.
REQ-028 The block SHALL sample req and dly only in IDLE.
REQ-029 Changes to req and dly during RUN and DONE SHALL be ignored; the grant SHALL be held until done even if the owner's req drops.
REQ-030 The pointer arithmetic SHALL wrap modulo N_REQ for non-power-of-two N_REQ: owner N_REQ-1 yields ptr 0.
REQ-031 done and gnt SHALL never have more than one bit set.
REQ-032 The done bit SHALL always equal the corresponding gnt bit.
REQ-033 All outputs SHALL be driven from registers or decoded from the registered state only, with no combinational path from inputs.

Reset
REQ-034 While RST = 1, the block SHALL immediately force state IDLE, ptr = 0, owner = 0, cnt = 0, gnt = 0, done = 0, aborted = 0 and busy = 0, independent of CLK.
REQ-035 Assertion of RST mid-RUN or in DONE SHALL discard the run with no done or aborted pulse.
REQ-036 After RST deasserts, the first arbitration SHALL start from index 0.

Verification (N_REQ=4, DLY_WIDTH=8)
REQ-037 Single request: req=0100, dly[2]=3 -> gnt=0100 on the next edge; cnt=3,2,1 for three cycles; then done=0100 for one cycle with cnt=0; then gnt=0000.
REQ-038 Round-robin: req=1111 held, all delays 1 -> grant order 0,1,2,3,0; each grant lasts 2 cycles (RUN, DONE), separated by 1 IDLE cycle.
REQ-039 Zero delay: req=0001, dly[0]=0 -> the grant edge enters DONE directly; done=0001 on the cycle after the grant edge; no RUN cycle.
REQ-040 Abort: owner 1, abort=1 while cnt=5 -> next edge gnt=0, cnt=0, aborted=1 for one cycle, no done; with req=1111 the next grant goes to 2.
REQ-041 Abort on the last cycle: abort=1 while cnt=1 -> abort wins; aborted pulses and done stays 0.
REQ-042 Async reset: RST pulsed between clock edges during RUN with cnt=4 -> gnt, cnt and busy are 0 before the next edge; after release, req=1010 grants index 1.
